// File: rtl/ff_readback_pkg.sv
// Shared types and constants for the flop readback serializer.
package ff_readback_pkg;

  localparam int unsigned StateW       = 2;
  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [StateW-1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StPar   = 2'd2,
    StDone  = 2'd3
  } rb_state_e;

endpackage

// File: rtl/ff_readback_ser_if.sv
// Capture request plus serial valid/ready link of the flop readback serializer.
interface ff_readback_ser_if #(
  parameter int unsigned WIDTH = ff_readback_pkg::DefaultWidth
);

  logic             cap_req;
  logic [WIDTH-1:0] cap_data;
  logic             cap_busy;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_data;
  logic             ser_last;
  logic             done;

  modport master (
    output cap_req,
    output cap_data,
    output ser_ready,
    input  cap_busy,
    input  ser_valid,
    input  ser_data,
    input  ser_last,
    input  done
  );

  modport slave (
    input  cap_req,
    input  cap_data,
    input  ser_ready,
    output cap_busy,
    output ser_valid,
    output ser_data,
    output ser_last,
    output done
  );

endinterface

// File: rtl/ff_readback_bitcnt.sv
// Bit counter for the readback frame: cleared on capture, bumped per accepted bit.
module ff_readback_bitcnt #(
  parameter int unsigned Width = 32,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic is_last_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_last_o = (cnt_q == CntW'(Width - 1));

endmodule

// File: rtl/ff_readback_ser.sv
// Snapshots a word of flop outputs and streams it LSB first over valid/ready.
// Define READBACK_PARITY_EN to append an even-parity bit after the data bits.
module ff_readback_ser
  import ff_readback_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input logic               clk,
  input logic               R,
  ff_readback_ser_if.slave  bus
);

  rb_state_e        state_d, state_q;
  logic [WIDTH-1:0] shreg_d, shreg_q;
  logic             cnt_clr, cnt_inc, cnt_last;
  logic             ser_valid, ser_data, ser_last, done;
`ifdef READBACK_PARITY_EN
  logic             parity_d, parity_q;
`endif

  ff_readback_bitcnt #(
    .Width (WIDTH),
    .CntW  (CNT_W)
  ) u_bitcnt (
    .clk_i     (clk),
    .rst_ni    (R),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .is_last_o (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    ser_last  = 1'b0;
    done      = 1'b0;
`ifdef READBACK_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.cap_req) begin
          shreg_d = bus.cap_data;
          cnt_clr = 1'b1;
`ifdef READBACK_PARITY_EN
          parity_d = ^bus.cap_data;
`endif
          state_d = StShift;
        end
      end
      StShift: begin
        ser_valid = 1'b1;
        ser_data  = shreg_q[0];
`ifndef READBACK_PARITY_EN
        ser_last  = cnt_last;
`endif
        if (bus.ser_ready) begin
          shreg_d = shreg_q >> 1;
          cnt_inc = 1'b1;
          if (cnt_last) begin
`ifdef READBACK_PARITY_EN
            state_d = StPar;
`else
            state_d = StDone;
`endif
          end
        end
      end
`ifdef READBACK_PARITY_EN
      StPar: begin
        ser_valid = 1'b1;
        ser_data  = parity_q;
        ser_last  = 1'b1;
        if (bus.ser_ready) begin
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
`ifdef READBACK_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
`ifdef READBACK_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Outputs decode from state only, so an async reset zeroes them immediately.
  assign bus.cap_busy  = (state_q != StIdle);
  assign bus.ser_valid = ser_valid;
  assign bus.ser_data  = ser_data;
  assign bus.ser_last  = ser_last;
  assign bus.done      = done;

endmodule

// File: tb/tb_ff_readback_ser.sv
// Directed bench for ff_readback_ser at WIDTH=8 and WIDTH=1.
module tb_ff_readback_ser;

  logic clk = 1'b0;
  logic R   = 1'b0;
  int   total = 0;
  int   bad   = 0;

`ifdef READBACK_PARITY_EN
  localparam int Nbits8 = 9;
  localparam int Nbits1 = 2;
`else
  localparam int Nbits8 = 8;
  localparam int Nbits1 = 1;
`endif

  always #5 clk = ~clk;

  ff_readback_ser_if #(.WIDTH(8)) bus8 ();
  ff_readback_ser_if #(.WIDTH(1)) bus1 ();

  ff_readback_ser #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .R   (R),
    .bus (bus8.slave)
  );

  ff_readback_ser #(.WIDTH(1)) u_dut1 (
    .clk (clk),
    .R   (R),
    .bus (bus1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle8(input string tag);
    chk({tag, " busy"},  32'(bus8.cap_busy),  32'd0);
    chk({tag, " valid"}, 32'(bus8.ser_valid), 32'd0);
    chk({tag, " data"},  32'(bus8.ser_data),  32'd0);
    chk({tag, " last"},  32'(bus8.ser_last),  32'd0);
    chk({tag, " done"},  32'(bus8.done),      32'd0);
  endtask

  // Streams one WIDTH=8 frame already captured; ready pattern 1,0,0,1 repeats when stall=1.
  task automatic stream8(input string tag, input logic [7:0] d, input logic par, input bit stall);
    logic [3:0] pat;
    logic       rdy;
    logic       exp_bit;
    int         k;
    int         c;
    pat = 4'b1001;
    k   = 0;
    c   = 0;
    while (k < Nbits8 && c < 64) begin
      rdy = stall ? pat[c % 4] : 1'b1;
      bus8.ser_ready = rdy;
      exp_bit = (k < 8) ? d[k[2:0]] : par;
      chk({tag, " valid"}, 32'(bus8.ser_valid), 32'd1);
      chk({tag, " busy"},  32'(bus8.cap_busy),  32'd1);
      chk({tag, " data"},  32'(bus8.ser_data),  32'(exp_bit));
      chk({tag, " last"},  32'(bus8.ser_last),  32'(k == Nbits8 - 1));
      chk({tag, " done"},  32'(bus8.done),      32'd0);
      tick();
      if (rdy) k++;
      c++;
    end
    chk({tag, " bits accepted"}, 32'(k), 32'(Nbits8));
    bus8.ser_ready = 1'b0;
    chk({tag, " done pulse"},  32'(bus8.done),      32'd1);
    chk({tag, " done valid"},  32'(bus8.ser_valid), 32'd0);
    chk({tag, " done busy"},   32'(bus8.cap_busy),  32'd1);
  endtask

  initial begin
    bus8.cap_req   = 1'b0;
    bus8.cap_data  = 8'h00;
    bus8.ser_ready = 1'b0;
    bus1.cap_req   = 1'b0;
    bus1.cap_data  = 1'b0;
    bus1.ser_ready = 1'b0;

    // Reset state, including across a clock edge while held.
    #2;
    chk_idle8("reset");
    chk("reset w1 busy",  32'(bus1.cap_busy),  32'd0);
    chk("reset w1 valid", 32'(bus1.ser_valid), 32'd0);
    tick();
    chk_idle8("reset edge");
    #3 R = 1'b1;
    tick();
    chk_idle8("post reset");

    // Frame A5 with ready held high.
    bus8.cap_data = 8'hA5;
    bus8.cap_req  = 1'b1;
    tick();
    bus8.cap_req  = 1'b0;
    stream8("a5", 8'hA5, 1'b0, 1'b0);
    tick();
    chk_idle8("a5 end");

    // Same frame with stalls.
    bus8.cap_req = 1'b1;
    tick();
    bus8.cap_req = 1'b0;
    stream8("stall", 8'hA5, 1'b0, 1'b1);
    tick();
    chk_idle8("stall end");

    // cap_req held and cap_data changed after capture: both ignored.
    bus8.cap_req = 1'b1;
    tick();
    bus8.cap_data = 8'hFF;
    stream8("held", 8'hA5, 1'b0, 1'b0);
    bus8.cap_req = 1'b0;
    tick();
    chk_idle8("held end");

    // Async reset at bit 3 aborts the frame without a done pulse.
    bus8.cap_data = 8'hA5;
    bus8.cap_req  = 1'b1;
    tick();
    bus8.cap_req   = 1'b0;
    bus8.ser_ready = 1'b1;
    tick();
    tick();
    tick();
    bus8.ser_ready = 1'b0;
    chk("abort pre valid", 32'(bus8.ser_valid), 32'd1);
    chk("abort pre last",  32'(bus8.ser_last),  32'd0);
    #2 R = 1'b0;
    #1;
    chk_idle8("abort async");
    tick();
    chk_idle8("abort held");
    #3 R = 1'b1;
    tick();
    chk_idle8("abort release");
    bus8.cap_data = 8'h3C;
    bus8.cap_req  = 1'b1;
    tick();
    bus8.cap_req  = 1'b0;
    stream8("restart", 8'h3C, 1'b0, 1'b0);
    tick();
    chk_idle8("restart end");

    // WIDTH=1: the single bit is also last.
    bus1.cap_data = 1'b1;
    bus1.cap_req  = 1'b1;
    tick();
    bus1.cap_req   = 1'b0;
    bus1.ser_ready = 1'b1;
    chk("w1 valid", 32'(bus1.ser_valid), 32'd1);
    chk("w1 data",  32'(bus1.ser_data),  32'd1);
    chk("w1 last",  32'(bus1.ser_last),  32'(Nbits1 == 1));
    chk("w1 busy",  32'(bus1.cap_busy),  32'd1);
    tick();
`ifdef READBACK_PARITY_EN
    chk("w1 par data", 32'(bus1.ser_data), 32'd1);
    chk("w1 par last", 32'(bus1.ser_last), 32'd1);
    tick();
`endif
    bus1.ser_ready = 1'b0;
    chk("w1 done",       32'(bus1.done),      32'd1);
    chk("w1 done valid", 32'(bus1.ser_valid), 32'd0);
    tick();
    chk("w1 done drop",  32'(bus1.done),      32'd0);
    chk("w1 idle busy",  32'(bus1.cap_busy),  32'd0);

`ifdef READBACK_PARITY_EN
    // Parity frames: 07 has three ones, 03 has two.
    bus8.cap_data = 8'h07;
    bus8.cap_req  = 1'b1;
    tick();
    bus8.cap_req  = 1'b0;
    stream8("par07", 8'h07, 1'b1, 1'b0);
    tick();
    chk_idle8("par07 end");
    bus8.cap_data = 8'h03;
    bus8.cap_req  = 1'b1;
    tick();
    bus8.cap_req  = 1'b0;
    stream8("par03", 8'h03, 1'b0, 1'b1);
    tick();
    chk_idle8("par03 end");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
